// File: rtl/gpi_pkg.sv
// Shared definitions for the NIOS GPI input conditioner: widths, sim debounce
// value and the counter-width helper.
package gpi_pkg;

  localparam int GPI_WIDTH        = 8;
  localparam int GPI_SIM_DEBOUNCE = 4;

  // Per-bit edge event on the stable value, consumed by the flag logic.
  typedef struct packed {
    logic rise;
    logic fall;
  } gpi_edge_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One GPI bit: synchroniser chain, persistence counter and stable flop.
// Also reports the stable-value edge that the top registers into flags.
module gpi_debounce_bit
  import gpi_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      pin_i,
  input  logic      bypass_i,
  output logic      stable_o,
  output gpi_edge_t edge_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   syn;

  assign syn = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (bypass_i) begin
      stable_d = syn;
      cnt_d    = '0;
    end else if (syn == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = syn;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {SYNC_STAGES{RESET_BIT}};
      cnt_q    <= '0;
      stable_q <= RESET_BIT;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Edge is taken from next-state so the flag lands on the same edge as out_port.
  assign stable_o    = stable_q;
  assign edge_o.rise = stable_d & ~stable_q;
  assign edge_o.fall = ~stable_d & stable_q;

endmodule

// File: rtl/nios_gpi_conditioner.sv
// Conditions raw board inputs for the NIOS GPI port: per-bit debounce,
// sticky rise/fall flags with software clear, and a level change interrupt.
module nios_gpi_conditioner
  import gpi_pkg::*;
#(
  parameter int               WIDTH           = GPI_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             bypass,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] rise_flags,
  output logic [WIDTH-1:0] fall_flags,
  output logic             change_irq
);

  gpi_edge_t [WIDTH-1:0] edge_w;
  logic [WIDTH-1:0]      rise_ev, fall_ev;
  logic [WIDTH-1:0]      rise_q, rise_d, fall_q, fall_d;
  logic                  change_irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpi_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_i    (pin_in[i]),
      .bypass_i (bypass),
      .stable_o (out_port[i]),
      .edge_o   (edge_w[i])
    );
    assign rise_ev[i] = edge_w[i].rise;
    assign fall_ev[i] = edge_w[i].fall;
  end

  // A set arriving with a clear wins so no edge is ever lost to software.
  assign rise_d = (rise_q & ~flag_clr) | rise_ev;
  assign fall_d = (fall_q & ~flag_clr) | fall_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q       <= '0;
      fall_q       <= '0;
      change_irq_q <= 1'b0;
    end else begin
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      change_irq_q <= |(rise_q | fall_q);
    end
  end

  assign rise_flags = rise_q;
  assign fall_flags = fall_q;
  assign change_irq = change_irq_q;

endmodule

// File: tb/tb_nios_gpi_conditioner.sv
// Scoreboard bench for nios_gpi_conditioner at WIDTH=8, SYNC=2, DEBOUNCE=4.
module tb_nios_gpi_conditioner;
  import gpi_pkg::*;

  localparam int W = 8;
  localparam int SEL_OUT = 0, SEL_RISE = 1, SEL_FALL = 2, SEL_IRQ = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pin_in, flag_clr, out_port, rise_flags, fall_flags;
  logic         bypass, change_irq;

  nios_gpi_conditioner #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (GPI_SIM_DEBOUNCE),
    .RESET_VALUE     ('0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pin_in     (pin_in),
    .bypass     (bypass),
    .flag_clr   (flag_clr),
    .out_port   (out_port),
    .rise_flags (rise_flags),
    .fall_flags (fall_flags),
    .change_irq (change_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    int           sel;
    logic [W-1:0] mask;
    logic [W-1:0] exp;
    string        tag;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pick(input int sel);
    case (sel)
      SEL_OUT:  return out_port;
      SEL_RISE: return rise_flags;
      SEL_FALL: return fall_flags;
      default:  return {{(W-1){1'b0}}, change_irq};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [W-1:0] mask,
                      input logic [W-1:0] exp, input int dly);
    sb_t e;
    e.cyc  = cyc + dly;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Advance one clock, then retire every expectation due on this cycle.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, 32'(pick(sb[i].sel) & sb[i].mask), 32'(sb[i].exp));
        sb.delete(i);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_all();
    flag_clr = '1;
    push("clr_rise", SEL_RISE, 8'hFF, 8'h00, 1);
    push("clr_fall", SEL_FALL, 8'hFF, 8'h00, 1);
    push("clr_irq",  SEL_IRQ,  8'h01, 8'h00, 2);
    step();
    flag_clr = '0;
    run(3);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"},  32'(out_port),   32'h00);
    chk({tag, "_rise"}, 32'(rise_flags), 32'h00);
    chk({tag, "_fall"}, 32'(fall_flags), 32'h00);
    chk({tag, "_irq"},  32'(change_irq), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; pin_in = 8'hFF; bypass = 1'b0; flag_clr = '0;
    run(3);
    chk_reset_state("rst");

    // Release with all pins high: normal debounce, flags set from reset value.
    reset_n = 1'b1;
    push("t1_out_early", SEL_OUT,  8'hFF, 8'h00, 5);
    push("t1_out",       SEL_OUT,  8'hFF, 8'hFF, 6);
    push("t1_rise",      SEL_RISE, 8'hFF, 8'hFF, 6);
    push("t1_irq_lag",   SEL_IRQ,  8'h01, 8'h00, 6);
    push("t1_irq",       SEL_IRQ,  8'h01, 8'h01, 7);
    run(9);
    clear_all();

    pin_in = 8'h00;
    push("all_fall_early", SEL_OUT,  8'hFF, 8'hFF, 5);
    push("all_fall_out",   SEL_OUT,  8'hFF, 8'h00, 6);
    push("all_fall_flag",  SEL_FALL, 8'hFF, 8'hFF, 6);
    run(8);
    clear_all();

    // Three-cycle glitch is rejected.
    pin_in = 8'h01;
    push("glitch3_out_a", SEL_OUT,  8'h01, 8'h00, 6);
    push("glitch3_out_b", SEL_OUT,  8'h01, 8'h00, 7);
    push("glitch3_rise",  SEL_RISE, 8'h01, 8'h00, 8);
    run(3);
    pin_in = 8'h00;
    run(10);

    // Four-cycle pulse is accepted, then its fall debounces too.
    pin_in = 8'h01;
    push("pulse4_early", SEL_OUT,  8'h01, 8'h00, 5);
    push("pulse4_out",   SEL_OUT,  8'h01, 8'h01, 6);
    push("pulse4_rise",  SEL_RISE, 8'h01, 8'h01, 6);
    run(4);
    pin_in = 8'h00;
    push("pulse4_back",  SEL_OUT,  8'h01, 8'h00, 6);
    push("pulse4_fall",  SEL_FALL, 8'h01, 8'h01, 6);
    run(8);
    clear_all();

    pin_in = 8'h08;
    run(8);
    clear_all();

    // Bit 3 falls alone.
    pin_in = 8'h00;
    push("b3_fall_early", SEL_OUT,  8'h08, 8'h08, 5);
    push("b3_fall_out",   SEL_OUT,  8'h08, 8'h00, 6);
    push("b3_fall_flag",  SEL_FALL, 8'hFF, 8'h08, 6);
    push("b3_rise_none",  SEL_RISE, 8'hFF, 8'h00, 6);
    run(8);

    // Clear lands on the same edge as a new bit-3 rise: set wins.
    pin_in = 8'h08;
    push("setwin_out",  SEL_OUT,  8'h08, 8'h08, 6);
    push("setwin_rise", SEL_RISE, 8'h08, 8'h08, 6);
    push("setwin_fall", SEL_FALL, 8'h08, 8'h00, 6);
    run(5);
    flag_clr = 8'h08;
    step();
    push("clr_alone_rise", SEL_RISE, 8'hFF, 8'h00, 1);
    push("clr_alone_irq1", SEL_IRQ,  8'h01, 8'h01, 1);
    push("clr_alone_irq0", SEL_IRQ,  8'h01, 8'h00, 2);
    step();
    flag_clr = '0;
    run(4);

    // Bypass: one-cycle pulse passes through three cycles later.
    bypass = 1'b1;
    push("byp_switch", SEL_OUT, 8'hFF, 8'h08, 2);
    run(3);
    pin_in = 8'h28;
    push("byp_pre",   SEL_OUT,  8'h20, 8'h00, 2);
    push("byp_out",   SEL_OUT,  8'h20, 8'h20, 3);
    push("byp_rise",  SEL_RISE, 8'h20, 8'h20, 3);
    push("byp_back",  SEL_OUT,  8'h20, 8'h00, 4);
    push("byp_fall",  SEL_FALL, 8'h20, 8'h20, 4);
    push("byp_rise2", SEL_RISE, 8'h20, 8'h20, 4);
    step();
    pin_in = 8'h08;
    run(6);
    bypass = 1'b0;
    run(2);
    clear_all();

    // Reset mid-count discards the partial count.
    pin_in = 8'hF7;
    run(4);
    reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    run(2);
    chk_reset_state("midrst_hold");
    reset_n = 1'b1;
    push("rerun_early", SEL_OUT,  8'hFF, 8'h00, 5);
    push("rerun_out",   SEL_OUT,  8'hFF, 8'hF7, 6);
    push("rerun_rise",  SEL_RISE, 8'hFF, 8'hF7, 6);
    push("rerun_fall",  SEL_FALL, 8'hFF, 8'h00, 6);
    push("rerun_irq",   SEL_IRQ,  8'h01, 8'h01, 7);
    run(9);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
